// File: rtl/ret_stack_pkg.sv
// ============================================================================
// ret_stack_pkg : shared constants and address type for the PC return stack
// Rev 1.0
// ============================================================================
`default_nettype none

package ret_stack_pkg;

  localparam int ADDR_W      = 12;
  localparam int STACK_DEPTH = 8;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage : ret_stack_pkg

`default_nettype wire

// File: rtl/ret_stack_if.sv
// ============================================================================
// ret_stack_if : sequencer <-> return-stack push/pop bus with status outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface ret_stack_if
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int LVL_W = $clog2(STACK_DEPTH) + 1
);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] ret_addr;
  logic             load;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, din, clr_err,
    input  ret_addr, load, level, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, din, clr_err,
    output ret_addr, load, level, empty, full, ovf, unf
  );

endinterface : ret_stack_if

`default_nettype wire

// File: rtl/ret_stack_regfile.sv
// ============================================================================
// stack_regfile : DEPTH x WIDTH storage, synchronous write, asynchronous read
// Rev 1.0
// ============================================================================
`default_nettype none

module stack_regfile
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we_i,
  input  wire logic [IDX_W-1:0] waddr_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic [IDX_W-1:0] raddr_i,
  output      logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : stack_regfile

`default_nettype wire

// File: rtl/ret_stack.sv
// ============================================================================
// ret_stack : return-address stack feeding the PC D input and its load strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ret_stack_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [LVL_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic             load_q, load_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             w_empty;
  logic             w_full;
  logic [IDX_W-1:0] w_top_idx;
  logic [WIDTH-1:0] w_top_data;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;

  assign w_empty   = (sp_q == '0);
  assign w_full    = (sp_q == LVL_W'(DEPTH));
  assign w_top_idx = IDX_W'(sp_q - LVL_W'(1));

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i (bus.din),
    .raddr_i (w_top_idx),
    .rdata_o (w_top_data)
  );

  always_comb begin
    sp_d       = sp_q;
    ret_addr_d = ret_addr_q;
    load_d     = 1'b1;
    ovf_d      = ovf_q & ~bus.clr_err;
    unf_d      = unf_q & ~bus.clr_err;
    w_we       = 1'b0;
    w_waddr    = sp_q[IDX_W-1:0];

    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (w_full) begin
          ovf_d = 1'b1;
        end else begin
          w_we = 1'b1;
          sp_d = sp_q + LVL_W'(1);
        end
      end
      2'b01: begin
        if (w_empty) begin
          unf_d = 1'b1;
        end else begin
          ret_addr_d = w_top_data;
          sp_d       = sp_q - LVL_W'(1);
          load_d     = 1'b0;
        end
      end
      2'b11: begin
        // Replace the top in place; an empty stack just forwards din to the PC.
        load_d = 1'b0;
        if (w_empty) begin
          ret_addr_d = bus.din;
        end else begin
          ret_addr_d = w_top_data;
          w_we       = 1'b1;
          w_waddr    = w_top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q       <= '0;
      ret_addr_q <= '0;
      load_q     <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      ret_addr_q <= ret_addr_d;
      load_q     <= load_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.ret_addr = ret_addr_q;
  assign bus.load     = load_q;
  assign bus.level    = sp_q;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

endmodule : ret_stack

`default_nettype wire
